gradient_mag_dir: RTL and testbench
===================================

GRADIENT_MAG_DIR -- requirements
Module: gradient_mag_dir

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 4096, pixels per line.
REQ-002 SHALL have parameter IMG_HEIGHT, default 3072, lines per frame.
REQ-003 SHALL have port i_clk  input  1  the single clock; all logic on rising edge.
REQ-004 SHALL have port i_aresetn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port s_axis_tdata  input  32  [31:16] Gx signed, [15:0] Gy signed.
REQ-006 SHALL have port s_axis_tvalid  input  1  input beat valid; no backpressure.
REQ-007 SHALL have port s_axis_tuser  input  1  start of frame, first pixel.
REQ-008 SHALL have port s_axis_tlast  input  1  end of line.
REQ-009 SHALL have port m_axis_tdata  output  32  [16:0] magnitude, [18:17] direction, [31:19] zero.
REQ-010 SHALL have ports m_axis_tvalid, m_axis_tuser, m_axis_tlast  output  1 each  aligned copies of the input sideband.
REQ-011 SHALL have port o_line_err  output  1  one-cycle pulse on a tlast position mismatch.
REQ-012 SHALL have port o_frame_err  output  1  one-cycle pulse on an unexpected tuser or a short frame.

Function
REQ-013 SHALL compute magnitude = |Gx| + |Gy| as 17-bit unsigned, with no saturation; Gx = Gy = -32768 gives 0x10000.
REQ-014 SHALL use 16-bit unsigned absolute values, so |-32768| = 32768.
REQ-015 SHALL quantise direction as follows:
- 0 (horizontal) when 256·|Gy| < 106·|Gx|.
- 2 (vertical) when 256·|Gy| > 618·|Gx|.
- Otherwise diagonal: 1 (45°) if Gx and Gy have the same sign, 3 (135°) if they differ.
REQ-016 SHALL output direction 0 when Gx = Gy = 0.
REQ-017 SHALL treat a zero component as positive for the sign test.
REQ-018 SHALL use a 3-stage pipeline: abs and sign capture, then sum and comparisons, then output register.
- Latency is exactly 3 cycles from input beat to m_axis_tvalid.
REQ-019 SHALL delay tvalid, tuser and tlast through the same 3 stages; a beat with tvalid = 0 produces m_axis_tvalid = 0 in the matching output cycle.
REQ-020 SHALL hold m_axis_tdata in cycles where m_axis_tvalid = 0.
REQ-021 SHALL count columns 0..IMG_WIDTH-1 and rows 0..IMG_HEIGHT-1 on valid beats only.
REQ-022 SHALL handle a valid beat with tuser as follows: column becomes 1, row becomes 0; if the counters were not at (0,0), o_frame_err pulses.
REQ-023 SHALL pulse o_line_err if tlast arrives at a column other than IMG_WIDTH-1, or does not arrive at column IMG_WIDTH-1.
- Either case: column wraps to 0 and row increments.
REQ-024 SHALL wrap the row to 0 after the last line; the next expected beat carries tuser.
REQ-025 SHALL let tuser and tlast on the same beat act independently, each applying its own rule.
REQ-026 SHALL assert the error pulses in the output cycle aligned with the offending beat, i.e. at 3-cycle latency.
REQ-027 SHALL pass data unchanged through the datapath when errors occur; errors are reported only, and the datapath is never stalled.

Reset
REQ-028 SHALL, while i_aresetn is low, clear all pipeline registers, counters, m_axis_* and error outputs to 0.
REQ-029 SHALL discard in-flight beats when reset is asserted mid-frame.
- After release, output resumes 3 cycles after the first new valid beat.
- The counters expect tuser again from (0,0).

Configuration
REQ-030 SHALL implement the direction logic (REQ-015 to REQ-017) only when macro GRAD_DIR_EN is defined.
- Without GRAD_DIR_EN: no comparator logic is built and m_axis_tdata[18:17] is tied to 0.
- Magnitude, latency and sideband behaviour are identical with and without the macro.

Structure
REQ-031 SHALL place the following in shared package gradient_pkg:
- Constants TAN22_Q8 = 106 and TAN67_Q8 = 618.
- Enum dir_t {DIR_0, DIR_45, DIR_90, DIR_135}.
- Field offsets of the input and output tdata.
REQ-032 SHALL implement the column/row checker as sub-module frame_pos_checker, fed by tvalid, tuser and tlast and producing the two error pulses.

Verification
REQ-033 SHALL verify Gx = 3, Gy = 4 -> magnitude 7, direction 1, 3 cycles later.
REQ-034 SHALL verify Gx = -4, Gy = 4 -> magnitude 8, direction 3; Gx = 10, Gy = 0 -> magnitude 10, direction 0; Gx = 0, Gy = -5 -> magnitude 5, direction 2.
REQ-035 SHALL verify Gx = Gy = -32768 -> m_axis_tdata[16:0] = 0x10000, direction 1; and Gx = Gy = 0 -> magnitude 0, direction 0.
REQ-036 SHALL verify, with IMG_WIDTH = 4 and IMG_HEIGHT = 2, a correct 8-beat frame -> no error pulses, and m_axis_tuser/m_axis_tlast appear on output beats 0, 3 and 7.
REQ-037 SHALL verify tlast at column 2 of a 4-wide line -> o_line_err pulses once; and tuser at row 1 -> o_frame_err pulses once and the counters restart.
REQ-038 SHALL verify reset asserted mid-frame for 2 cycles -> all outputs 0 with no stale beat emitted, then a clean frame processes without errors; the bench is run with and without GRAD_DIR_EN, checking that bits [18:17] are 0 when the macro is undefined.

Source files
------------

// File: rtl/gradient_pkg.sv
// Shared constants, direction encoding and tdata field layout for the gradient
// magnitude/direction block.
package gradient_pkg;

  localparam int unsigned TAN22_Q8 = 106;
  localparam int unsigned TAN67_Q8 = 618;

  typedef enum logic [1:0] {
    DIR_0   = 2'd0,
    DIR_45  = 2'd1,
    DIR_90  = 2'd2,
    DIR_135 = 2'd3
  } dir_t;

  localparam int unsigned IN_GX_LSB   = 16;
  localparam int unsigned IN_GY_LSB   = 0;
  localparam int unsigned COMP_W      = 16;
  localparam int unsigned OUT_MAG_LSB = 0;
  localparam int unsigned OUT_MAG_W   = 17;
  localparam int unsigned OUT_DIR_LSB = 17;
  localparam int unsigned OUT_PAD_W   = 13;

  // Unsigned magnitude of a signed 16-bit value; -32768 maps to 32768.
  function automatic logic [15:0] abs16(input logic [15:0] v);
    abs16 = v[15] ? (16'(~v) + 16'd1) : v;
  endfunction

endpackage

// File: rtl/frame_pos_checker.sv
// Tracks column/row position on valid beats and flags tlast/tuser placement
// errors; the pulses are registered, one cycle after the offending beat.
module frame_pos_checker #(
  parameter int IMG_WIDTH  = 4096,
  parameter int IMG_HEIGHT = 3072
) (
  input  logic clk,
  input  logic rst_n,
  input  logic valid,
  input  logic user,
  input  logic last,
  output logic line_err,
  output logic frame_err
);

  localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  logic [CW-1:0] col_r, col_s, eff_col_s;
  logic [RW-1:0] row_r, row_s, eff_row_s;
  logic          line_err_r, frame_err_r;
  logic          line_err_s, frame_err_s, at_end_s;

  // A tuser beat is treated as sitting at (0,0); tlast is then judged there.
  always_comb begin
    eff_col_s   = user ? '0 : col_r;
    eff_row_s   = user ? '0 : row_r;
    at_end_s    = (eff_col_s == COL_LAST);
    col_s       = col_r;
    row_s       = row_r;
    line_err_s  = 1'b0;
    frame_err_s = 1'b0;
    if (valid) begin
      line_err_s  = (last != at_end_s);
      frame_err_s = user && ((col_r != '0) || (row_r != '0));
      if (last || at_end_s) begin
        col_s = '0;
        row_s = (eff_row_s == ROW_LAST) ? '0 : (eff_row_s + RW'(1));
      end else begin
        col_s = eff_col_s + CW'(1);
        row_s = eff_row_s;
      end
    end else begin
      col_s = col_r;
      row_s = row_r;
    end
  end

  // Position counters and registered error pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_r       <= '0;
      row_r       <= '0;
      line_err_r  <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      col_r       <= col_s;
      row_r       <= row_s;
      line_err_r  <= line_err_s;
      frame_err_r <= frame_err_s;
    end
  end

  assign line_err  = line_err_r;
  assign frame_err = frame_err_r;

endmodule

// File: rtl/gradient_mag_dir.sv
// Three-stage |Gx|+|Gy| magnitude with optional 4-way direction quantisation
// (built only when GRAD_DIR_EN is defined) and frame position checking.
module gradient_mag_dir
  import gradient_pkg::*;
#(
  parameter int IMG_WIDTH  = 4096,
  parameter int IMG_HEIGHT = 3072
) (
  input  logic        i_clk,
  input  logic        i_aresetn,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tuser,
  input  logic        s_axis_tlast,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tuser,
  output logic        m_axis_tlast,
  output logic        o_line_err,
  output logic        o_frame_err
);

  logic [15:0] abs_x_r, abs_y_r;
  logic        v1_r, u1_r, l1_r;
  logic [16:0] mag_s, mag_r;
  dir_t        dir_s, dir_r;
  logic        v2_r, u2_r, l2_r, le2_r, fe2_r;
  logic        chk_line_err, chk_frame_err;
  logic [31:0] tdata_r;
  logic        v3_r, u3_r, l3_r, le3_r, fe3_r;

  frame_pos_checker #(
    .IMG_WIDTH (IMG_WIDTH),
    .IMG_HEIGHT(IMG_HEIGHT)
  ) u_frame_pos_checker (
    .clk      (i_clk),
    .rst_n    (i_aresetn),
    .valid    (s_axis_tvalid),
    .user     (s_axis_tuser),
    .last     (s_axis_tlast),
    .line_err (chk_line_err),
    .frame_err(chk_frame_err)
  );

  // Stage 1: absolute values and sideband capture.
  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      abs_x_r <= 16'd0;
      abs_y_r <= 16'd0;
      v1_r    <= 1'b0;
      u1_r    <= 1'b0;
      l1_r    <= 1'b0;
    end else begin
      abs_x_r <= abs16(s_axis_tdata[IN_GX_LSB +: COMP_W]);
      abs_y_r <= abs16(s_axis_tdata[IN_GY_LSB +: COMP_W]);
      v1_r    <= s_axis_tvalid;
      u1_r    <= s_axis_tuser;
      l1_r    <= s_axis_tlast;
    end
  end

  assign mag_s = 17'(abs_x_r) + 17'(abs_y_r);

`ifdef GRAD_DIR_EN
  logic        neg_x_r, neg_y_r;
  logic [25:0] y_q8_s, lo_s, hi_s;

  // Stage 1: sign capture (zero counts as positive).
  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      neg_x_r <= 1'b0;
      neg_y_r <= 1'b0;
    end else begin
      neg_x_r <= s_axis_tdata[IN_GX_LSB + COMP_W - 1];
      neg_y_r <= s_axis_tdata[IN_GY_LSB + COMP_W - 1];
    end
  end

  // Compare 256*|Gy| against tan(22.5)/tan(67.5) scaled |Gx|.
  always_comb begin
    y_q8_s = {2'b00, abs_y_r, 8'h00};
    lo_s   = 26'(abs_x_r) * 26'(TAN22_Q8);
    hi_s   = 26'(abs_x_r) * 26'(TAN67_Q8);
    dir_s  = DIR_0;
    if ((abs_x_r == 16'd0) && (abs_y_r == 16'd0)) begin
      dir_s = DIR_0;
    end else if (y_q8_s < lo_s) begin
      dir_s = DIR_0;
    end else if (y_q8_s > hi_s) begin
      dir_s = DIR_90;
    end else if (neg_x_r == neg_y_r) begin
      dir_s = DIR_45;
    end else begin
      dir_s = DIR_135;
    end
  end
`else
  assign dir_s = DIR_0;
`endif

  // Stage 2: magnitude/direction and aligned sideband/error bits.
  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      mag_r <= 17'd0;
      dir_r <= DIR_0;
      v2_r  <= 1'b0;
      u2_r  <= 1'b0;
      l2_r  <= 1'b0;
      le2_r <= 1'b0;
      fe2_r <= 1'b0;
    end else begin
      mag_r <= mag_s;
      dir_r <= dir_s;
      v2_r  <= v1_r;
      u2_r  <= u1_r;
      l2_r  <= l1_r;
      le2_r <= chk_line_err;
      fe2_r <= chk_frame_err;
    end
  end

  // Stage 3: output register; tdata holds while no valid beat is present.
  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      tdata_r <= 32'd0;
      v3_r    <= 1'b0;
      u3_r    <= 1'b0;
      l3_r    <= 1'b0;
      le3_r   <= 1'b0;
      fe3_r   <= 1'b0;
    end else begin
      if (v2_r) begin
        tdata_r <= {{OUT_PAD_W{1'b0}}, dir_r, mag_r};
      end else begin
        tdata_r <= tdata_r;
      end
      v3_r  <= v2_r;
      u3_r  <= u2_r;
      l3_r  <= l2_r;
      le3_r <= le2_r;
      fe3_r <= fe2_r;
    end
  end

  assign m_axis_tdata  = tdata_r;
  assign m_axis_tvalid = v3_r;
  assign m_axis_tuser  = u3_r;
  assign m_axis_tlast  = l3_r;
  assign o_line_err    = le3_r;
  assign o_frame_err   = fe3_r;

endmodule

// File: tb/tb_gradient_mag_dir.sv
// Table-driven bench with a cycle-accurate scoreboard for gradient_mag_dir on a
// 4x2 frame; expected direction bits follow GRAD_DIR_EN.
module tb_gradient_mag_dir;

  localparam int W = 4;
  localparam int H = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] s_tdata = 32'd0;
  logic        s_tvalid = 1'b0, s_tuser = 1'b0, s_tlast = 1'b0;
  logic [31:0] m_tdata;
  logic        m_tvalid, m_tuser, m_tlast, line_err, frame_err;

  always #5 clk = ~clk;

  gradient_mag_dir #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .i_clk        (clk),
    .i_aresetn    (rst_n),
    .s_axis_tdata (s_tdata),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tuser (s_tuser),
    .s_axis_tlast (s_tlast),
    .m_axis_tdata (m_tdata),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tuser (m_tuser),
    .m_axis_tlast (m_tlast),
    .o_line_err   (line_err),
    .o_frame_err  (frame_err)
  );

  typedef struct {
    logic [15:0] gx, gy;
    logic [16:0] mag;
    logic [1:0]  dir;
  } data_t;

  typedef struct {
    logic v, u, l;
    int   di;
    logic le, fe;
  } beat_t;

  typedef struct {
    logic        v, u, l, le, fe;
    logic [31:0] data;
  } exp_t;

  data_t       dtab [8];
  beat_t       btab [39];
  exp_t        sbq [$];
  logic [31:0] last_data;
  int          vectors = 0;
  int          miscompares = 0;

  function automatic beat_t mk(input logic v, input logic u, input logic l,
                               input int di, input logic le, input logic fe);
    beat_t b;
    b.v = v; b.u = u; b.l = l; b.di = di; b.le = le; b.fe = fe;
    return b;
  endfunction

  task automatic check_out();
    exp_t e;
    if (sbq.size() >= 3) begin
      e = sbq.pop_front();
      vectors++;
      if ({m_tvalid, m_tuser, m_tlast, line_err, frame_err, m_tdata} !==
          {e.v, e.u, e.l, e.le, e.fe, e.data}) begin
        miscompares++;
        $display("FAIL out_beat %0d: got v=%b u=%b l=%b le=%b fe=%b data=%h, expected v=%b u=%b l=%b le=%b fe=%b data=%h",
                 vectors, m_tvalid, m_tuser, m_tlast, line_err, frame_err, m_tdata,
                 e.v, e.u, e.l, e.le, e.fe, e.data);
      end
    end
  endtask

  task automatic step(input beat_t b);
    exp_t  e;
    data_t d;
    logic [1:0] xd;
    @(negedge clk);
    check_out();
    if (b.v) begin
      d = dtab[b.di];
    end else begin
      d.gx = 16'($urandom);
      d.gy = 16'($urandom);
      d.mag = 17'd0;
      d.dir = 2'd0;
    end
    s_tdata  = {d.gx, d.gy};
    s_tvalid = b.v;
    s_tuser  = b.u;
    s_tlast  = b.l;
`ifdef GRAD_DIR_EN
    xd = d.dir;
`else
    xd = 2'd0;
`endif
    if (b.v) last_data = {13'd0, xd, d.mag};
    e.v = b.v; e.u = b.u; e.l = b.l; e.le = b.le; e.fe = b.fe;
    e.data = last_data;
    sbq.push_back(e);
  endtask

  // Two-cycle reset: pipeline contents are discarded, outputs read as zero.
  task automatic pulse_reset();
    exp_t z;
    z.v = 1'b0; z.u = 1'b0; z.l = 1'b0; z.le = 1'b0; z.fe = 1'b0; z.data = 32'd0;
    @(negedge clk);
    rst_n = 1'b0;
    s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0;
    sbq.delete();
    last_data = 32'd0;
    repeat (3) sbq.push_back(z);
    step(mk(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0));
    step(mk(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0));
    rst_n = 1'b1;
  endtask

  initial begin
    dtab[0] = '{16'sd3,      16'sd4,      17'd7,       2'd1};
    dtab[1] = '{-16'sd4,     16'sd4,      17'd8,       2'd3};
    dtab[2] = '{16'sd10,     16'sd0,      17'd10,      2'd0};
    dtab[3] = '{16'sd0,      -16'sd5,     17'd5,       2'd2};
    dtab[4] = '{16'h8000,    16'h8000,    17'h10000,   2'd1};
    dtab[5] = '{16'sd0,      16'sd0,      17'd0,       2'd0};
    dtab[6] = '{16'sd100,    -16'sd1,     17'd101,     2'd0};
    dtab[7] = '{-16'sd7,     -16'sd20,    17'd27,      2'd2};

    // clean frame with an idle gap
    btab[0]  = mk(1, 1, 0, 0, 0, 0);
    btab[1]  = mk(1, 0, 0, 1, 0, 0);
    btab[2]  = mk(1, 0, 0, 2, 0, 0);
    btab[3]  = mk(1, 0, 1, 3, 0, 0);
    btab[4]  = mk(0, 0, 0, 0, 0, 0);
    btab[5]  = mk(1, 0, 0, 4, 0, 0);
    btab[6]  = mk(1, 0, 0, 5, 0, 0);
    btab[7]  = mk(1, 0, 0, 6, 0, 0);
    btab[8]  = mk(1, 0, 1, 7, 0, 0);
    // early tlast at column 2
    btab[9]  = mk(1, 1, 0, 0, 0, 0);
    btab[10] = mk(1, 0, 0, 1, 0, 0);
    btab[11] = mk(1, 0, 1, 2, 1, 0);
    btab[12] = mk(1, 0, 0, 3, 0, 0);
    btab[13] = mk(1, 0, 0, 4, 0, 0);
    btab[14] = mk(1, 0, 0, 5, 0, 0);
    btab[15] = mk(1, 0, 1, 6, 0, 0);
    // tuser at row 1, then a missing tlast at column 3
    btab[16] = mk(1, 1, 0, 7, 0, 0);
    btab[17] = mk(1, 0, 0, 0, 0, 0);
    btab[18] = mk(1, 0, 0, 1, 0, 0);
    btab[19] = mk(1, 0, 1, 2, 0, 0);
    btab[20] = mk(1, 1, 0, 3, 0, 1);
    btab[21] = mk(1, 0, 0, 4, 0, 0);
    btab[22] = mk(1, 0, 0, 5, 0, 0);
    btab[23] = mk(1, 0, 1, 6, 0, 0);
    btab[24] = mk(1, 0, 0, 7, 0, 0);
    btab[25] = mk(1, 0, 0, 0, 0, 0);
    btab[26] = mk(1, 0, 0, 1, 0, 0);
    btab[27] = mk(1, 0, 0, 2, 1, 0);
    // partial frame, interrupted by reset
    btab[28] = mk(1, 1, 0, 3, 0, 0);
    btab[29] = mk(1, 0, 0, 4, 0, 0);
    btab[30] = mk(1, 0, 0, 5, 0, 0);
    // clean frame after reset
    btab[31] = mk(1, 1, 0, 4, 0, 0);
    btab[32] = mk(1, 0, 0, 5, 0, 0);
    btab[33] = mk(1, 0, 0, 6, 0, 0);
    btab[34] = mk(1, 0, 1, 7, 0, 0);
    btab[35] = mk(1, 0, 0, 0, 0, 0);
    btab[36] = mk(1, 0, 0, 1, 0, 0);
    btab[37] = mk(1, 0, 0, 2, 0, 0);
    btab[38] = mk(1, 0, 1, 3, 0, 0);

    last_data = 32'd0;
    pulse_reset();
    for (int i = 0; i <= 30; i++) step(btab[i]);
    pulse_reset();
    for (int i = 31; i <= 38; i++) step(btab[i]);
    repeat (4) step(mk(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
